// File: rtl/fp_align_unpack_pkg.sv
// Shared fp add/sub package: op codes, widths, shift limits, bundles.
// Used by the align/unpack front end and the operation stage.
package fp_align_unpack_pkg;

  localparam int EXP_W  = 16;
  localparam int FRAC_W = 54;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_DSUB = 2'b11;
  localparam logic [1:0] OP_SSUB = 2'b01;

  localparam logic [EXP_W-1:0] SAT_D = 16'd54;
  localparam logic [EXP_W-1:0] SAT_S = 16'd25;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              special;
  } unpk_t;

  typedef struct packed {
    logic              mode;
    logic [1:0]        op;
    logic              sign;
    logic [EXP_W-1:0]  large_exp;
    logic [EXP_W-1:0]  diff;
    logic [FRAC_W-1:0] large_frac;
    logic [FRAC_W-1:0] small_frac;
    logic              special;
  } s1_t;

  typedef struct packed {
    logic              mode;
    logic [1:0]        op;
    logic              sign;
    logic [EXP_W-1:0]  large_exp;
    logic [FRAC_W-1:0] large_frac;
    logic [FRAC_W-1:0] small_frac;
    logic              sticky;
    logic              special;
  } s2_t;

  function automatic logic [1:0] op_code(
    input logic mode,
    input logic eff_sub
  );
    if (!eff_sub) return OP_ADD;
    return mode ? OP_DSUB : OP_SSUB;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one IEEE operand (double or single).
// Ports: mode (1=double), op (64-bit operand) -> res {sign,exp,frac,special}.
module fp_unpack
  import fp_align_unpack_pkg::*;
(
  input  logic        mode,
  input  logic [63:0] op,
  output unpk_t       res
);

  logic hid;

  always_comb begin
    res = '0;
    hid = 1'b0;
    if (mode) begin
      hid         = |op[62:52];
      res.sign    = op[63];
      res.special = &op[62:52];
      // denormal/zero aligns as exponent 1
      res.exp     = hid ? {5'b0, op[62:52]} : 16'd1;
      res.frac    = {1'b0, hid, op[51:0]};
    end else begin
      hid         = |op[30:23];
      res.sign    = op[31];
      res.special = &op[30:23];
      res.exp     = hid ? {8'b0, op[30:23]} : 16'd1;
      res.frac    = {29'b0, 1'b0, hid, op[22:0]};
    end
  end

endmodule

// File: rtl/fp_align_unpack.sv
// fp add/sub front end: unpack, magnitude order, align smaller fraction.
// Ports: i_clk/i_rst, in handshake i_valid/o_ready, out o_valid/i_ready.
module fp_align_unpack
  import fp_align_unpack_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mode,
  input  logic              i_sub,
  input  logic [63:0]       i_a,
  input  logic [63:0]       i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_mode,
  output logic [1:0]        o_op,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_large_exp,
  output logic [FRAC_W-1:0] o_large_frac54,
  output logic [FRAC_W-1:0] o_small_frac54,
  output logic              o_sticky,
  output logic              o_special
);

  unpk_t ua;
  unpk_t ub;

  fp_unpack u_unpack_a (
    .mode (i_mode),
    .op   (i_a),
    .res  (ua)
  );

  fp_unpack u_unpack_b (
    .mode (i_mode),
    .op   (i_b),
    .res  (ub)
  );

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  s1_t  s1_d;
  s1_t  s1_q;
  s2_t  s2_d;
  s2_t  s2_q;

  assign s1_adv  = ~s2_valid | i_ready;
  assign o_ready = ~s1_valid | s1_adv;

  logic a_large;
  logic eff_sub;

  always_comb begin
    a_large = {ua.exp, ua.frac} >= {ub.exp, ub.frac};
    eff_sub = i_sub ^ ua.sign ^ ub.sign;
    s1_d         = '0;
    s1_d.mode    = i_mode;
    s1_d.op      = op_code(i_mode, eff_sub);
    s1_d.special = ua.special | ub.special;
    if (a_large) begin
      s1_d.sign       = ua.sign;
      s1_d.large_exp  = ua.exp;
      s1_d.diff       = ua.exp - ub.exp;
      s1_d.large_frac = ua.frac;
      s1_d.small_frac = ub.frac;
    end else begin
      // B's sign is flipped when subtracting
      s1_d.sign       = ub.sign ^ i_sub;
      s1_d.large_exp  = ub.exp;
      s1_d.diff       = ub.exp - ua.exp;
      s1_d.large_frac = ub.frac;
      s1_d.small_frac = ua.frac;
    end
  end

  logic [EXP_W-1:0]  sat;
  logic [FRAC_W-1:0] mask;

  always_comb begin
    sat  = s1_q.mode ? SAT_D : SAT_S;
    mask = '0;
    s2_d            = '0;
    s2_d.mode       = s1_q.mode;
    s2_d.op         = s1_q.op;
    s2_d.sign       = s1_q.sign;
    s2_d.large_exp  = s1_q.large_exp;
    s2_d.large_frac = s1_q.large_frac;
    s2_d.special    = s1_q.special;
    if (s1_q.diff >= sat) begin
      s2_d.small_frac = '0;
      s2_d.sticky     = |s1_q.small_frac;
    end else begin
      mask = ~({FRAC_W{1'b1}} << s1_q.diff);
      s2_d.small_frac = s1_q.small_frac >> s1_q.diff;
      s2_d.sticky     = |(s1_q.small_frac & mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid) s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  assign o_valid        = s2_valid;
  assign o_mode         = s2_q.mode;
  assign o_op           = s2_q.op;
  assign o_sign         = s2_q.sign;
  assign o_large_exp    = s2_q.large_exp;
  assign o_large_frac54 = s2_q.large_frac;
  assign o_small_frac54 = s2_q.small_frac;
  assign o_sticky       = s2_q.sticky;
  assign o_special      = s2_q.special;

endmodule

// File: tb/tb_fp_align_unpack.sv
// Directed self-checking bench for fp_align_unpack.
// Hand-computed vectors, one task per scenario.
module tb_fp_align_unpack;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_mode;
  logic        i_sub;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic        o_mode;
  logic [1:0]  o_op;
  logic        o_sign;
  logic [15:0] o_large_exp;
  logic [53:0] o_large_frac54;
  logic [53:0] o_small_frac54;
  logic        o_sticky;
  logic        o_special;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [53:0] ONE_D = 54'h10000000000000;
  localparam logic [63:0] D_1   = 64'h3FF0000000000000;

  fp_align_unpack dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_mode         (i_mode),
    .i_sub          (i_sub),
    .i_a            (i_a),
    .i_b            (i_b),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_mode         (o_mode),
    .o_op           (o_op),
    .o_sign         (o_sign),
    .o_large_exp    (o_large_exp),
    .o_large_frac54 (o_large_frac54),
    .o_small_frac54 (o_small_frac54),
    .o_sticky       (o_sticky),
    .o_special      (o_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one bundle with i_ready high; returns cycles until o_valid.
  task automatic run_one(input logic m, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         output int lat);
    @(negedge clk);
    i_mode = m; i_sub = s; i_a = a; i_b = b;
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_mode = 1'b0; i_sub = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", o_valid);
    end
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", o_ready);
    end
    n_checks++;
    if ({o_large_exp, o_large_frac54, o_small_frac54, o_op} !== '0) begin
      n_fail++; $display("FAIL reset_data got exp=%h lf=%h sf=%h op=%b want 0",
                         o_large_exp, o_large_frac54, o_small_frac54, o_op);
    end
    rst = 1'b0;
  endtask

  task automatic test_double_add();
    int lat;
    run_one(1'b1, 1'b0, D_1, D_1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL dadd_latency got %0d want 2", lat);
    end
    n_checks++;
    if (o_large_exp !== 16'h03FF || o_large_frac54 !== ONE_D ||
        o_small_frac54 !== ONE_D) begin
      n_fail++; $display("FAIL dadd_data got %h %h %h want 03ff %h %h",
                         o_large_exp, o_large_frac54, o_small_frac54, ONE_D, ONE_D);
    end
    n_checks++;
    if (o_op !== 2'b00 || o_sticky !== 1'b0 || o_sign !== 1'b0 ||
        o_mode !== 1'b1 || o_special !== 1'b0) begin
      n_fail++; $display("FAIL dadd_flags got op=%b st=%b sg=%b md=%b sp=%b want 00 0 0 1 0",
                         o_op, o_sticky, o_sign, o_mode, o_special);
    end
  endtask

  task automatic test_single_sub();
    int lat;
    run_one(1'b0, 1'b1, 64'h40400000, 64'h3F800000, lat);
    n_checks++;
    if (lat !== 2 || o_large_exp !== 16'h0080 ||
        o_large_frac54 !== 54'hC00000 || o_small_frac54 !== 54'h400000) begin
      n_fail++; $display("FAIL ssub_data got lat=%0d %h %h %h want 2 0080 c00000 400000",
                         lat, o_large_exp, o_large_frac54, o_small_frac54);
    end
    n_checks++;
    if (o_op !== 2'b01 || o_sign !== 1'b0 || o_sticky !== 1'b0) begin
      n_fail++; $display("FAIL ssub_flags got op=%b sg=%b st=%b want 01 0 0",
                         o_op, o_sign, o_sticky);
    end
  endtask

  task automatic test_single_swap();
    int lat;
    run_one(1'b0, 1'b1, 64'h3F800000, 64'h40400000, lat);
    n_checks++;
    if (lat !== 2 || o_large_exp !== 16'h0080 ||
        o_large_frac54 !== 54'hC00000 || o_small_frac54 !== 54'h400000) begin
      n_fail++; $display("FAIL sswap_data got lat=%0d %h %h %h want 2 0080 c00000 400000",
                         lat, o_large_exp, o_large_frac54, o_small_frac54);
    end
    n_checks++;
    if (o_op !== 2'b01 || o_sign !== 1'b1) begin
      n_fail++; $display("FAIL sswap_flags got op=%b sg=%b want 01 1", o_op, o_sign);
    end
  endtask

  task automatic test_shift_bounds();
    int lat;
    // diff 60: saturated
    run_one(1'b1, 1'b0, 64'h43B0000000000000, D_1, lat);
    n_checks++;
    if (o_large_exp !== 16'h043B || o_small_frac54 !== '0 || o_sticky !== 1'b1) begin
      n_fail++; $display("FAIL d_diff60 got %h %h st=%b want 043b 0 1",
                         o_large_exp, o_small_frac54, o_sticky);
    end
    // diff 53: just below limit, all shifted out
    run_one(1'b1, 1'b0, D_1, 64'h3CA0000000000000, lat);
    n_checks++;
    if (o_small_frac54 !== '0 || o_sticky !== 1'b1) begin
      n_fail++; $display("FAIL d_diff53 got %h st=%b want 0 1", o_small_frac54, o_sticky);
    end
    // diff 52: hidden bit lands in bit 0
    run_one(1'b1, 1'b0, D_1, 64'h3CB0000000000000, lat);
    n_checks++;
    if (o_small_frac54 !== 54'd1 || o_sticky !== 1'b0) begin
      n_fail++; $display("FAIL d_diff52 got %h st=%b want 1 0", o_small_frac54, o_sticky);
    end
    // single diff 3 with low bit set
    run_one(1'b0, 1'b0, 64'h3F800000, 64'h3E000001, lat);
    n_checks++;
    if (o_small_frac54 !== 54'h100000 || o_sticky !== 1'b1 ||
        o_large_exp !== 16'h007F) begin
      n_fail++; $display("FAIL s_diff3 got %h st=%b exp=%h want 100000 1 007f",
                         o_small_frac54, o_sticky, o_large_exp);
    end
    // single diff 25: saturated
    run_one(1'b0, 1'b0, 64'h3F800000, 64'h33000000, lat);
    n_checks++;
    if (o_small_frac54 !== '0 || o_sticky !== 1'b1) begin
      n_fail++; $display("FAIL s_diff25 got %h st=%b want 0 1", o_small_frac54, o_sticky);
    end
  endtask

  task automatic test_misc();
    int lat;
    // upper half ignored in single mode
    run_one(1'b0, 1'b0, 64'hFFFFFFFF_3F800000, 64'h00000000_3F800000, lat);
    n_checks++;
    if (o_large_exp !== 16'h007F || o_large_frac54 !== 54'h800000 ||
        o_small_frac54 !== 54'h800000 || o_sign !== 1'b0 || o_op !== 2'b00) begin
      n_fail++; $display("FAIL s_upper got %h %h %h sg=%b op=%b want 007f 800000 800000 0 00",
                         o_large_exp, o_large_frac54, o_small_frac54, o_sign, o_op);
    end
    // 1.0 + (-1.0): effective double subtract, tie keeps A large
    run_one(1'b1, 1'b0, D_1, 64'hBFF0000000000000, lat);
    n_checks++;
    if (o_op !== 2'b11 || o_sign !== 1'b0 || o_small_frac54 !== ONE_D) begin
      n_fail++; $display("FAIL d_effsub got op=%b sg=%b sf=%h want 11 0 %h",
                         o_op, o_sign, o_small_frac54, ONE_D);
    end
    // Inf operand flags special
    run_one(1'b1, 1'b0, 64'h7FF0000000000000, D_1, lat);
    n_checks++;
    if (o_special !== 1'b1 || o_large_exp !== 16'h07FF) begin
      n_fail++; $display("FAIL d_special got sp=%b exp=%h want 1 07ff",
                         o_special, o_large_exp);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int sent;
    int got;
    int cyc;
    logic acc_in;
    logic acc_out;
    sent = 0; got = 0; cyc = 0; held = '0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      i_ready = (cyc >= 5);
      i_valid = (sent < 4);
      i_mode = 1'b1; i_sub = 1'b0;
      i_a = {1'b0, 11'h400 + 11'(sent), 52'b0};
      i_b = D_1;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (o_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_ready cyc=%0d got %b want 0", cyc, o_ready);
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_large_exp !== 16'h0400) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b exp=%h want 1 0400",
                             cyc, o_valid, o_large_exp);
        end
      end
      acc_in  = i_valid & o_ready;
      acc_out = o_valid & i_ready;
      held    = o_large_exp;
      @(posedge clk);
      if (acc_out) begin
        n_checks++;
        if (exp_q.size() == 0 || held !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_order got %h want %h", held,
                             exp_q.size() ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (acc_in) begin
        exp_q.push_back(16'h0400 + 16'(sent));
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    n_checks++;
    if (got !== 4 || sent !== 4 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL bp_count got out=%0d in=%0d left=%0d want 4 4 0",
                         got, sent, exp_q.size());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_dup got o_valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; i_mode = 1'b1; i_sub = 1'b0;
    i_a = D_1; i_b = D_1;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got v=%b r=%b want 0 1", o_valid, o_ready);
    end
    i_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale got %b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_double_add();
    test_single_sub();
    test_single_swap();
    test_shift_bounds();
    test_misc();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
